if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch producer for the IF/ID pipeline register: owns the PC, issues requests
//  to instruction memory, tags responses with fetch address, buffers up to FIFO_DEPTH words.
//  Presents {instr_o, pc_o, valid_o} to IF/ID.
//  Stalls on hazards, redirects on jump/branch from ID/EX.
//  Invalid cycles drive a 32'b0 NOP bubble, the same value IF/ID loads on flush.
// PARAMETERS
//  ADDR_W      14         PC / imem byte-address width
//  INSTR_W     32         instruction width
//  FIFO_DEPTH  2          max fetched-not-consumed words (outstanding + buffered); 1..4
//  RESET_PC    14'h0000   PC value loaded on reset
// PORTS
//  clk              in   1        clock; all state updates on rising edge
//  rst_n            in   1        reset, asynchronous, active-high
//  stall_i          in   1        1 = downstream holds; do not pop FIFO head
//  redirect_i       in   1        1 = jump/branch taken; flush and refetch
//  redirect_addr_i  in   ADDR_W   new PC; bits [1:0] ignored (forced 0)
//  imem_req_o       out  1        fetch request valid
//  imem_addr_o      out  ADDR_W   fetch byte address, word aligned
//  imem_gnt_i       in   1        request accepted this cycle (req & gnt = handshake)
//  imem_rvalid_i    in   1        response valid; responses return in order, >=1 cycle after gnt
//  imem_rdata_i     in   INSTR_W  response instruction
//  instr_o          out  INSTR_W  instruction to IF/ID; 0 when valid_o=0
//  pc_o             out  ADDR_W   address of instr_o; 0 when valid_o=0
//  valid_o          out  1        FIFO head valid
// BEHAVIOUR
//  Reset (async, rst_n=1):
//   - pc=RESET_PC, state=IDLE, FIFO empty, outstanding=0, discard=0.
//   - All outputs 0.
//  FSM states:
//   - IDLE -> FETCH: unconditional, first cycle after reset release.
//   - FETCH -> DRAIN: redirect_i=1 while discard count (outstanding minus same-cycle rvalid) > 0.
//   - FETCH -> FETCH: redirect_i=1 with nothing in flight.
//   - DRAIN -> FETCH: when discard reaches 0.
//   - DRAIN + redirect_i: reload PC; discard keeps counting down (already covers all in flight).
//  Issue (FETCH only):
//   - imem_req_o = 1 iff outstanding + fifo_count < FIFO_DEPTH and redirect_i=0.
//   - imem_addr_o = pc.
//   - On req & gnt: pc <= pc + 4, wrapping mod 2^ADDR_W; outstanding++.
//   - req/addr stay stable until gnt.
//   - Address tags are kept in an in-order tag queue.
//  Response:
//   - FETCH: rvalid pushes {rdata, tag} into FIFO; outstanding--.
//   - DRAIN: rvalid is dropped; discard-- and outstanding--.
//   - Credit check guarantees no push into a full FIFO. Push to full = assertion failure.
//  Output:
//   - valid_o = FIFO non-empty; instr_o/pc_o = head, combinational from FIFO regs.
//   - Pop when valid_o & !stall_i.
//   - Output is stable from rising edge, so IF/ID can sample on the falling edge.
//   - Same-cycle push and pop on a full FIFO is legal; count unchanged.
//   - Zero-latency bypass from imem to output is not allowed: first instr appears the cycle after rvalid.
//  Redirect (priority over stall and issue):
//   - Same edge: FIFO flushed (valid_o=0 next cycle).
//   - pc <= {redirect_addr_i[ADDR_W-1:2], 2'b00}.
//   - No request issued in the redirect cycle; any pending ungranted req is withdrawn.
//   - rvalid arriving in the redirect cycle counts as stale (dropped).
//  Stall:
//   - Freezes FIFO head.
//   - Fetching continues until credits are exhausted, then imem_req_o=0.
//  Reset mid-operation: all state cleared immediately; in-flight imem responses after release are ignored.
//   - imem must also be reset by the same rst_n.
// TESTING
//  1. Reset release, gnt=1, 1-cycle rvalid:
//     -> req addr 0x0000, 0x0004, 0x0008...
//     -> valid_o from cycle 3; pc_o 0,4,8 with matching instr.
//  2. stall_i=1 for 5 cycles, DEPTH=2:
//     -> exactly 2 words fetched, then imem_req_o=0.
//     -> instr_o/pc_o frozen; resumes in order after stall drops.
//  3. redirect_i=1, addr=0x0123, with 2 responses outstanding:
//     -> next cycle valid_o=0, state DRAIN; both stale responses dropped.
//     -> next request addr 0x0120; first valid pc_o=0x0120.
//  4. PC wrap: redirect to 0x3FFC:
//     -> requests 0x3FFC then 0x0000; pc_o follows.
//  5. gnt held low 4 cycles:
//     -> imem_req_o and imem_addr_o held stable.
//     -> redirect during the wait withdraws req; new address issued next cycle.
//  6. rst_n asserted mid-fetch with FIFO full:
//     -> outputs 0 immediately (async).
//     -> after release, first req addr = RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer for IF/ID: owns the PC, issues in-order imem requests,
// tags responses with their fetch address and buffers them in a small FIFO.

module if_fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           rd_ptr, wr_ptr;

  // Explicit wrap so non-power-of-two depths (3) cycle correctly
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  assign rdata = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst_n)
    (push && !pop && !flush) |-> (count < CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst_n)
    (pop && !flush) |-> (count != '0));

endmodule

module if_fetch_unit #(
  parameter int                ADDR_W     = 14,
  parameter int                INSTR_W    = 32,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_addr_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               valid_o
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_word_t;

  state_e            state, state_n;
  logic [CW-1:0]     discard, discard_n;
  logic [CW-1:0]     out_cnt, fifo_cnt;
  logic [CW:0]       credits_used;
  logic [ADDR_W-1:0] pc, tag_head, redirect_pc;
  logic              issue, rsp_acc, push, pop;
  fetch_word_t       push_word, head_word;

  assign redirect_pc = redirect_addr_i & ~ADDR_W'(3);

  // A response is only meaningful while something is in flight; anything
  // else (e.g. leftovers across a reset) is ignored.
  assign rsp_acc      = imem_rvalid_i && (out_cnt != '0);
  assign credits_used = {1'b0, out_cnt} + {1'b0, fifo_cnt};
  assign issue        = imem_req_o && imem_gnt_i;
  assign push         = (state == FETCH) && rsp_acc && !redirect_i;
  assign pop          = valid_o && !stall_i;
  assign push_word    = '{instr: imem_rdata_i, pc: tag_head};

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state   <= IDLE;
      discard <= '0;
    end else begin
      state   <= state_n;
      discard <= discard_n;
    end
  end

  always_comb begin
    state_n     = state;
    discard_n   = discard;
    imem_req_o  = 1'b0;
    imem_addr_o = '0;
    case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        imem_req_o  = !redirect_i && (credits_used < (CW+1)'(FIFO_DEPTH));
        imem_addr_o = imem_req_o ? pc : '0;
        // A response landing in the redirect cycle is already stale
        if (redirect_i) begin
          discard_n = out_cnt - CW'(rsp_acc);
          if (discard_n != '0)
            state_n = DRAIN;
        end
      end
      DRAIN: begin
        discard_n = discard - CW'(rsp_acc);
        if (discard_n == '0)
          state_n = FETCH;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      pc <= RESET_PC;
    else if (redirect_i)
      pc <= redirect_pc;
    else if (issue)
      pc <= pc + ADDR_W'(4);
  end

  // Tag queue depth tracks requests granted but not yet answered
  if_fetch_fifo #(.W(ADDR_W), .DEPTH(FIFO_DEPTH), .CW(CW)) u_tag_q (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (1'b0),
    .push  (issue),
    .wdata (pc),
    .pop   (rsp_acc),
    .rdata (tag_head),
    .count (out_cnt)
  );

  if_fetch_fifo #(.W($bits(fetch_word_t)), .DEPTH(FIFO_DEPTH), .CW(CW)) u_out_q (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_i),
    .push  (push),
    .wdata (push_word),
    .pop   (pop),
    .rdata (head_word),
    .count (fifo_cnt)
  );

  assign valid_o = (fifo_cnt != '0);
  assign instr_o = valid_o ? head_word.instr : '0;
  assign pc_o    = valid_o ? head_word.pc    : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: per-cycle vector table plus hand sequences
// for redirect/drain, PC wrap, grant back-pressure and mid-fetch reset.

module tb_if_fetch_unit;
  localparam int AW = 14;

  logic          clk, rst_n, stall, redir, gnt, rvalid, req, valid;
  logic [AW-1:0] raddr, addr, pc;
  logic [31:0]   rdata, instr;
  int            mem_lat;
  int            n_chk, n_fail;

  typedef struct {
    logic          stall;
    logic          redir;
    logic [AW-1:0] raddr;
    logic          gnt;
    logic          req;
    logic [AW-1:0] addr;
    logic          vld;
    logic [AW-1:0] pc;
  } vec_t;

  vec_t t1[17];

  if_fetch_unit #(.ADDR_W(AW), .INSTR_W(32), .FIFO_DEPTH(2), .RESET_PC(14'h0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall),
    .redirect_i      (redir),
    .redirect_addr_i (raddr),
    .imem_req_o      (req),
    .imem_addr_o     (addr),
    .imem_gnt_i      (gnt),
    .imem_rvalid_i   (rvalid),
    .imem_rdata_i    (rdata),
    .instr_o         (instr),
    .pc_o            (pc),
    .valid_o         (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fword(input logic [AW-1:0] a);
    return {16'hC0DE, 2'b00, a};
  endfunction

  // imem model: fixed latency mem_lat (1..4) cycles from grant to rvalid
  logic [3:0]       pv;
  logic [3:0][31:0] pd;
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pv <= '0;
      pd <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        pv[i] <= pv[i+1];
        pd[i] <= pd[i+1];
      end
      pv[3] <= 1'b0;
      if (req && gnt) begin
        pv[mem_lat-1] <= 1'b1;
        pd[mem_lat-1] <= fword(addr);
      end
    end
  end
  assign rvalid = pv[0];
  assign rdata  = pd[0];

  function automatic vec_t v(input logic s, input logic r, input logic [AW-1:0] ra, input logic g,
                             input logic rq, input logic [AW-1:0] a, input logic vl, input logic [AW-1:0] p);
    vec_t t;
    t.stall = s; t.redir = r; t.raddr = ra; t.gnt = g;
    t.req = rq; t.addr = a; t.vld = vl; t.pc = p;
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic apply(input string tag, input vec_t t);
    @(negedge clk);
    stall = t.stall; redir = t.redir; raddr = t.raddr; gnt = t.gnt;
    #1;
    check({tag, ".req"},   32'(req),   32'(t.req));
    check({tag, ".addr"},  32'(addr),  32'(t.addr));
    check({tag, ".valid"}, 32'(valid), 32'(t.vld));
    check({tag, ".pc"},    32'(pc),    32'(t.pc));
    check({tag, ".instr"}, instr,      t.vld ? fword(t.pc) : 32'h0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".req"},   32'(req),   32'h0);
    check({tag, ".addr"},  32'(addr),  32'h0);
    check({tag, ".valid"}, 32'(valid), 32'h0);
    check({tag, ".pc"},    32'(pc),    32'h0);
    check({tag, ".instr"}, instr,      32'h0);
  endtask

  // Leaves the next negedge as cycle 0 (state IDLE) after release
  task automatic do_reset(input int lat);
    rst_n = 1'b1; stall = 1'b0; redir = 1'b0; raddr = '0; gnt = 1'b1; mem_lat = lat;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_fail = 0;
    stall = 1'b0; redir = 1'b0; raddr = '0; gnt = 1'b1; mem_lat = 1;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1 check_zero("reset");

    // Streaming with 1-cycle imem, then a 5-cycle stall with DEPTH=2
    t1[0]  = v(0, 0, 0, 1,  0, 14'h000, 0, 14'h000);
    t1[1]  = v(0, 0, 0, 1,  1, 14'h000, 0, 14'h000);
    t1[2]  = v(0, 0, 0, 1,  1, 14'h004, 0, 14'h000);
    t1[3]  = v(0, 0, 0, 1,  0, 14'h000, 1, 14'h000);
    t1[4]  = v(0, 0, 0, 1,  1, 14'h008, 1, 14'h004);
    t1[5]  = v(0, 0, 0, 1,  1, 14'h00C, 0, 14'h000);
    t1[6]  = v(0, 0, 0, 1,  0, 14'h000, 1, 14'h008);
    t1[7]  = v(0, 0, 0, 1,  1, 14'h010, 1, 14'h00C);
    t1[8]  = v(1, 0, 0, 1,  1, 14'h014, 0, 14'h000);
    t1[9]  = v(1, 0, 0, 1,  0, 14'h000, 1, 14'h010);
    t1[10] = v(1, 0, 0, 1,  0, 14'h000, 1, 14'h010);
    t1[11] = v(1, 0, 0, 1,  0, 14'h000, 1, 14'h010);
    t1[12] = v(1, 0, 0, 1,  0, 14'h000, 1, 14'h010);
    t1[13] = v(0, 0, 0, 1,  0, 14'h000, 1, 14'h010);
    t1[14] = v(0, 0, 0, 1,  1, 14'h018, 1, 14'h014);
    t1[15] = v(0, 0, 0, 1,  1, 14'h01C, 0, 14'h000);
    t1[16] = v(0, 0, 0, 1,  0, 14'h000, 1, 14'h018);

    do_reset(1);
    for (int i = 0; i < 17; i++)
      apply($sformatf("stream_c%0d", i), t1[i]);

    // Redirect with two responses in flight (3-cycle imem): both dropped
    do_reset(3);
    apply("redir_c0",  v(0, 0, 0,        1,  0, 14'h000, 0, 14'h000));
    apply("redir_c1",  v(0, 0, 0,        1,  1, 14'h000, 0, 14'h000));
    apply("redir_c2",  v(0, 0, 0,        1,  1, 14'h004, 0, 14'h000));
    apply("redir_c3",  v(0, 1, 14'h0123, 1,  0, 14'h000, 0, 14'h000));
    apply("redir_c4",  v(0, 0, 0,        1,  0, 14'h000, 0, 14'h000));
    apply("redir_c5",  v(0, 0, 0,        1,  0, 14'h000, 0, 14'h000));
    apply("redir_c6",  v(0, 0, 0,        1,  1, 14'h120, 0, 14'h000));
    apply("redir_c7",  v(0, 0, 0,        1,  1, 14'h124, 0, 14'h000));
    apply("redir_c8",  v(0, 0, 0,        1,  0, 14'h000, 0, 14'h000));
    apply("redir_c9",  v(0, 0, 0,        1,  0, 14'h000, 0, 14'h000));
    apply("redir_c10", v(0, 0, 0,        1,  0, 14'h000, 1, 14'h120));
    apply("redir_c11", v(0, 0, 0,        1,  1, 14'h128, 1, 14'h124));

    // Redirect to top of memory; a response in the redirect cycle is stale
    do_reset(1);
    apply("wrap_c0", v(0, 0, 0,        1,  0, 14'h000,  0, 14'h000));
    apply("wrap_c1", v(0, 0, 0,        1,  1, 14'h000,  0, 14'h000));
    apply("wrap_c2", v(0, 1, 14'h3FFC, 1,  0, 14'h000,  0, 14'h000));
    apply("wrap_c3", v(0, 0, 0,        1,  1, 14'h3FFC, 0, 14'h000));
    apply("wrap_c4", v(0, 0, 0,        1,  1, 14'h000,  0, 14'h000));
    apply("wrap_c5", v(0, 0, 0,        1,  0, 14'h000,  1, 14'h3FFC));
    apply("wrap_c6", v(0, 0, 0,        1,  1, 14'h004,  1, 14'h000));

    // Grant withheld, then withdrawn by a redirect with unaligned target
    do_reset(1);
    apply("gnt_c0", v(0, 0, 0,        0,  0, 14'h000, 0, 14'h000));
    apply("gnt_c1", v(0, 0, 0,        0,  1, 14'h000, 0, 14'h000));
    apply("gnt_c2", v(0, 0, 0,        0,  1, 14'h000, 0, 14'h000));
    apply("gnt_c3", v(0, 0, 0,        0,  1, 14'h000, 0, 14'h000));
    apply("gnt_c4", v(0, 0, 0,        0,  1, 14'h000, 0, 14'h000));
    apply("gnt_c5", v(0, 1, 14'h0041, 0,  0, 14'h000, 0, 14'h000));
    apply("gnt_c6", v(0, 0, 0,        1,  1, 14'h040, 0, 14'h000));
    apply("gnt_c7", v(0, 0, 0,        1,  1, 14'h044, 0, 14'h000));
    apply("gnt_c8", v(1, 0, 0,        1,  0, 14'h000, 1, 14'h040));
    apply("gnt_c9", v(1, 0, 0,        1,  0, 14'h000, 1, 14'h040));

    // FIFO now full under stall: asynchronous reset clears outputs mid-cycle
    #1 rst_n = 1'b1;
    #1 check_zero("midreset");
    do_reset(1);
    apply("rel_c0", v(0, 0, 0, 1,  0, 14'h000, 0, 14'h000));
    apply("rel_c1", v(0, 0, 0, 1,  1, 14'h000, 0, 14'h000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
